spr_window_gen_r: RTL and testbench

SPR_WINDOW_GEN_R -- requirements
Module: spr_window_gen_r

---
 rtl/spr_window_gen_r.sv | 96 +++++++++
 tb/tb_spr_window_gen_r.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spr_window_gen_r.sv
// spr_window_gen_r: 1x3 horizontal pixel window with column/row tracking and a per-frame line-length check.
// Define SPR_WIN_EDGE_REPLICATE_EN to pad missing neighbours with curr instead of 0.
module spr_window_gen_r #(
    parameter int DW = 12,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_hs,
    input  logic          i_vs,
    input  logic [DW-1:0] i_pix,
    output logic          o_hs,
    output logic          o_vs,
    output logic [DW-1:0] prev,
    output logic [DW-1:0] curr,
    output logic [DW-1:0] next,
    output logic [CW-1:0] o_col,
    output logic [CW-1:0] o_row,
    output logic          o_len_err
);
    logic          hs1_q, hs2_q, vs1_q, vs2_q;
    logic [DW-1:0] s0_q, s1_q, s2_q, pad;
    logic          v0_q, v1_q, v2_q;
    logic [CW-1:0] col_q, col_d, row_q, row_d, cnt_q, cnt_d, ref_q, ref_d;
    logic          ref_v_q, ref_v_d, err_q, err_d, acc, vs_rise, line_end;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    always_comb begin
        acc      = i_hs && i_vs;
        vs_rise  = i_vs && !vs1_q;
        line_end = i_vs && !acc && (cnt_q != '0);
        cnt_d    = acc ? sat_inc(cnt_q) : '0;
        ref_v_d  = !vs_rise && (ref_v_q || line_end);
        ref_d    = (line_end && !ref_v_q) ? cnt_q : ref_q;
        err_d    = !vs_rise && (err_q || (line_end && ref_v_q && (cnt_q != ref_q)));
        col_d    = v1_q ? sat_inc(col_q) : (hs2_q ? col_q : '0);
        row_d    = !vs2_q ? '0 : ((hs2_q && !hs1_q) ? sat_inc(row_q) : row_q);
    end

    // Dropping i_vs kills every in-flight pixel, so a truncated frame never leaks out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs1_q   <= 1'b0;
            hs2_q   <= 1'b0;
            vs1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= '0;
            ref_v_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            hs1_q   <= i_hs;
            hs2_q   <= hs1_q;
            vs1_q   <= i_vs;
            vs2_q   <= vs1_q;
            s0_q    <= acc ? i_pix : '0;
            s1_q    <= s0_q;
            s2_q    <= s1_q;
            v0_q    <= acc;
            v1_q    <= v0_q && i_vs;
            v2_q    <= v1_q && i_vs;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            ref_v_q <= ref_v_d;
            err_q   <= err_d;
        end
    end

`ifdef SPR_WIN_EDGE_REPLICATE_EN
    assign pad = s1_q;
`else
    assign pad = '0;
`endif

    assign o_hs      = hs2_q;
    assign o_vs      = vs2_q;
    assign curr      = v1_q ? s1_q : '0;
    assign prev      = v1_q ? (v2_q ? s2_q : pad) : '0;
    assign next      = v1_q ? (v0_q ? s0_q : pad) : '0;
    assign o_col     = hs2_q ? col_q : '0;
    assign o_row     = vs2_q ? row_q : '0;
    assign o_len_err = err_q;
endmodule

// File: tb/tb_spr_window_gen_r.sv
// tb_spr_window_gen_r: randomized and directed checks of spr_window_gen_r against a cycle-history reference model.
module tb_spr_window_gen_r;
    localparam int DW = 12;
    localparam int CW = 12;
    localparam int MAXV = (1 << CW) - 1;
`ifdef SPR_WIN_EDGE_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, i_hs = 1'b0, i_vs = 1'b0;
    logic [DW-1:0] i_pix = '0;
    logic o_hs, o_vs, o_len_err;
    logic [DW-1:0] prev, curr, next;
    logic [CW-1:0] o_col, o_row;

    spr_window_gen_r #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .i_hs(i_hs), .i_vs(i_vs), .i_pix(i_pix),
        .o_hs(o_hs), .o_vs(o_vs), .prev(prev), .curr(curr), .next(next),
        .o_col(o_col), .o_row(o_row), .o_len_err(o_len_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    typedef struct { bit hs; bit vs; logic [DW-1:0] pix; } stim_t;
    stim_t q[$];

    // history of the last three sampled edges (index 0 = most recent)
    bit a0, a1, a2, h0, h1, vv0, vv1;
    logic [DW-1:0] p0, p1, p2;
    bit e_hs, e_vs, e_cv, pcv, pohs;
    logic [DW-1:0] e_prev, e_curr, e_next;
    logic [CW-1:0] e_col, e_row;
    int mcol, mrow;

    task automatic clr_model();
        a0 = 0; a1 = 0; a2 = 0; h0 = 0; h1 = 0; vv0 = 0; vv1 = 0;
        p0 = '0; p1 = '0; p2 = '0; pcv = 0; pohs = 0; mcol = 0; mrow = 0;
    endtask

    task automatic step(input bit hs, input bit vs, input logic [DW-1:0] pix);
        logic [DW-1:0] pad;
        bit pv;
        i_hs = hs; i_vs = vs; i_pix = pix;
        @(posedge clk);
        mcol = pcv ? (mcol < MAXV ? mcol + 1 : mcol) : (!pohs ? 0 : mcol);
        a2 = a1; a1 = a0; a0 = hs && vs;
        p2 = p1; p1 = p0; p0 = pix;
        h1 = h0; h0 = hs; vv1 = vv0; vv0 = vs;
        e_hs = h1; e_vs = vv1;
        e_cv = a1 && vs;
        pv = a2 && vv1 && vs;
        pad = REPL ? p1 : '0;
        e_curr = e_cv ? p1 : '0;
        e_next = e_cv ? (a0 ? p0 : pad) : '0;
        e_prev = e_cv ? (pv ? p2 : pad) : '0;
        if (!e_vs) mrow = 0;
        else if (pohs && !e_hs) mrow = (mrow < MAXV) ? mrow + 1 : mrow;
        e_col = CW'(mcol); e_row = CW'(mrow);
        pcv = e_cv; pohs = e_hs;
        #1;
    endtask

    task automatic add(input bit hs, input bit vs, input logic [DW-1:0] pix);
        stim_t s;
        s.hs = hs; s.vs = vs; s.pix = pix;
        q.push_back(s);
    endtask

    task automatic add_blank(input int n, input bit vs);
        for (int i = 0; i < n; i++) add(1'b0, vs, DW'($urandom));
    endtask

    task automatic add_line(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 1'b1, DW'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1; i_hs = 1'b0; i_vs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clr_model();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_hs = 1'b1; i_vs = 1'b1; i_pix = DW'($urandom);
            @(posedge clk); #1;
            total++;
            if ({o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err} !== '0) begin
                bad++;
                $display("FAIL reset_outs got=%h need=0", {o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        clr_model();
    endtask

    task automatic test_basic();
        do_reset();
        q.delete();
        add_blank(2, 1'b1);
        for (int i = 1; i <= 4; i++) add(1'b1, 1'b1, DW'(16 * i));
        add_blank(4, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            total++;
            if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                bad++;
                $display("FAIL basic_win i=%0d got=%h need=%h", i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
            end
            if (e_cv) begin
                total++;
                if (o_col !== e_col) begin bad++; $display("FAIL basic_col got=%0d need=%0d", o_col, e_col); end
            end
            if (i >= 3 && i <= 6) begin
                total++;
                if (curr !== DW'(16 * (i - 2)) || o_col !== CW'(i - 3)) begin
                    bad++;
                    $display("FAIL basic_seq i=%0d curr=%h col=%0d need curr=%h col=%0d", i, curr, o_col, DW'(16 * (i - 2)), i - 3);
                end
            end
            if (i == 3) begin
                total++;
                if (prev !== (REPL ? 12'h010 : 12'h000)) begin bad++; $display("FAIL basic_first_prev got=%h", prev); end
            end
            if (i == 6) begin
                total++;
                if (next !== (REPL ? 12'h040 : 12'h000)) begin bad++; $display("FAIL basic_last_next got=%h", next); end
            end
        end
    endtask

    task automatic test_lines();
        logic [DW-1:0] px[$];
        int k;
        q.delete();
        add_blank(2, 1'b0);
        add_blank(1, 1'b1);
        for (int l = 0; l < 3; l++) begin add_line(8); add_blank(1, 1'b1); end
        add_blank(3, 1'b1);
        foreach (q[i]) if (q[i].hs && q[i].vs) px.push_back(q[i].pix);
        k = 0;
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            total++;
            if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                bad++;
                $display("FAIL lines_win i=%0d got=%h need=%h", i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
            end
            if (e_cv) begin
                total++;
                if (curr !== px[k] || o_col !== CW'(k % 8) || o_row !== CW'(k / 8)) begin
                    bad++;
                    $display("FAIL lines_pos k=%0d curr=%h col=%0d row=%0d need %h %0d %0d", k, curr, o_col, o_row, px[k], k % 8, k / 8);
                end
                k++;
            end
        end
        total++;
        if (k !== 24 || o_len_err !== 1'b0) begin bad++; $display("FAIL lines_end count=%0d err=%b need 24 0", k, o_len_err); end
    endtask

    task automatic test_len_err();
        q.delete();
        add_blank(2, 1'b0);
        add_blank(1, 1'b1);
        add_line(8); add_blank(1, 1'b1);
        add_line(7); add_blank(3, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            total++;
            if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                bad++;
                $display("FAIL len_win i=%0d got=%h need=%h", i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
            end
            if (i == 12) begin
                total++;
                if (o_len_err !== 1'b0) begin bad++; $display("FAIL len_first_line err=%b need 0", o_len_err); end
            end
        end
        total++;
        if (o_len_err !== 1'b1) begin bad++; $display("FAIL len_set err=%b need 1", o_len_err); end
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        total++;
        if (o_len_err !== 1'b1) begin bad++; $display("FAIL len_hold err=%b need 1", o_len_err); end
        step(1'b0, 1'b1, '0);
        total++;
        if (o_len_err !== 1'b0) begin bad++; $display("FAIL len_clear err=%b need 0", o_len_err); end
    endtask

    task automatic test_vs_fall();
        q.delete();
        add_blank(2, 1'b0);
        add_blank(1, 1'b1);
        add_line(5); add_blank(1, 1'b1);
        add_line(3);
        add(1'b1, 1'b0, DW'($urandom));
        add(1'b1, 1'b0, DW'($urandom));
        add_blank(3, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            total++;
            if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                bad++;
                $display("FAIL vsfall_win i=%0d got=%h need=%h", i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
            end
            if (e_vs) begin
                total++;
                if (o_row !== e_row) begin bad++; $display("FAIL vsfall_row got=%0d need=%0d", o_row, e_row); end
            end
        end
        total++;
        if (o_len_err !== 1'b0) begin bad++; $display("FAIL vsfall_err err=%b need 0", o_len_err); end
    endtask

    task automatic test_rst_mid();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b1, 1'b1, 12'h111);
        step(1'b1, 1'b1, 12'h222);
        step(1'b1, 1'b1, 12'h333);
        rst = 1'b1;
        #1;
        total++;
        if ({o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_async got=%h need=0", {o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err});
        end
        @(posedge clk); #1;
        total++;
        if ({o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err} !== '0) begin
            bad++;
            $display("FAIL rstmid_hold got=%h need=0", {o_hs, o_vs, prev, curr, next, o_col, o_row, o_len_err});
        end
        @(negedge clk);
        rst = 1'b0;
        clr_model();
        q.delete();
        add_blank(1, 1'b1);
        add(1'b1, 1'b1, 12'hABC);
        add_blank(3, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            total++;
            if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                bad++;
                $display("FAIL rstmid_win i=%0d got=%h need=%h", i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
            end
            if (i == 2) begin
                total++;
                if (curr !== 12'hABC || prev !== (REPL ? 12'hABC : 12'h000) || next !== (REPL ? 12'hABC : 12'h000) || o_col !== '0) begin
                    bad++;
                    $display("FAIL rstmid_single prev=%h curr=%h next=%h col=%0d", prev, curr, next, o_col);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 6; f++) begin
            int lens[$];
            int nl, base;
            bit exp_err;
            q.delete();
            nl = $urandom_range(2, 4);
            base = $urandom_range(1, 10);
            exp_err = 0;
            add_blank($urandom_range(2, 3), 1'b0);
            add_blank(1, 1'b1);
            for (int l = 0; l < nl; l++) begin
                lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : base);
                if (lens[l] != lens[0]) exp_err = 1;
                add_line(lens[l]);
                add_blank($urandom_range(1, 3), 1'b1);
            end
            add_blank(1, 1'b1);
            for (int i = 0; i < q.size(); i++) begin
                step(q[i].hs, q[i].vs, q[i].pix);
                total++;
                if ({o_hs, o_vs, prev, curr, next} !== {e_hs, e_vs, e_prev, e_curr, e_next}) begin
                    bad++;
                    $display("FAIL rand_win f=%0d i=%0d got=%h need=%h", f, i, {o_hs, o_vs, prev, curr, next}, {e_hs, e_vs, e_prev, e_curr, e_next});
                end
                if (e_cv) begin
                    total++;
                    if (o_col !== e_col) begin bad++; $display("FAIL rand_col f=%0d got=%0d need=%0d", f, o_col, e_col); end
                end
                if (e_vs) begin
                    total++;
                    if (o_row !== e_row) begin bad++; $display("FAIL rand_row f=%0d got=%0d need=%0d", f, o_row, e_row); end
                end
            end
            total++;
            if (o_len_err !== exp_err) begin bad++; $display("FAIL rand_err f=%0d got=%b need=%b", f, o_len_err, exp_err); end
        end
    endtask

    task automatic test_saturation();
        q.delete();
        add_blank(2, 1'b0);
        add_blank(1, 1'b1);
        add_line(MAXV + 5); add_blank(1, 1'b1);
        for (int l = 0; l < MAXV + 5; l++) begin add_line(1); add_blank(1, 1'b1); end
        add_blank(2, 1'b1);
        for (int i = 0; i < q.size(); i++) begin
            step(q[i].hs, q[i].vs, q[i].pix);
            if (e_cv) begin
                total++;
                if (o_col !== e_col || curr !== e_curr) begin bad++; $display("FAIL sat_col i=%0d col=%0d need=%0d", i, o_col, e_col); end
            end
            if (e_vs) begin
                total++;
                if (o_row !== e_row) begin bad++; $display("FAIL sat_row i=%0d got=%0d need=%0d", i, o_row, e_row); end
            end
        end
        total++;
        if (o_row !== CW'(MAXV)) begin bad++; $display("FAIL sat_row_final got=%0d need=%0d", o_row, MAXV); end
    endtask

    initial begin
        clr_model();
        test_reset();
        test_basic();
        test_lines();
        test_len_err();
        test_vs_fall();
        test_rst_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
